// File: rtl/mmu_arbiter.sv
// Round-robin arbiter sharing one MMU port among NUM_REQ requesters.
// Optional watchdog enabled by defining MMU_ARB_TIMEOUT_EN.
module mmu_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_we,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [NUM_REQ-1:0]          req_err,
   output logic [DATA_W-1:0]           req_rdata,
   output logic                        mmu_valid,
   output logic                        mmu_we,
   output logic [ADDR_W-1:0]           mmu_address,
   output logic [DATA_W-1:0]           mmu_wdata,
   input  logic                        mmu_ready,
   input  logic [DATA_W-1:0]           mmu_data,
   output logic [$clog2(NUM_REQ)-1:0]  grant_id,
   output logic                        busy
);

   localparam int GW = $clog2(NUM_REQ);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]         r_state;
   logic [GW-1:0]      r_last;
   logic [GW-1:0]      r_grant;
   logic               r_mmu_valid;
   logic               r_we;
   logic [ADDR_W-1:0]  r_addr;
   logic [DATA_W-1:0]  r_wdata;
   logic [DATA_W-1:0]  r_rdata;
   logic [GW-1:0]      w_win;
   logic               w_any;
   logic [NUM_REQ-1:0] w_ready;
`ifdef MMU_ARB_TIMEOUT_EN
   logic [15:0]        r_cnt;
   logic               r_timeout;
`endif

   // Search from last_grant+1 upward; the nearest requester wins, so scan
   // farthest-first and let nearer hits overwrite.
   function automatic logic [GW-1:0] f_pick(
      input logic [NUM_REQ-1:0] v,
      input logic [GW-1:0]      last
   );
      logic [GW-1:0] p;
      int            idx;
      p = last;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (v[idx]) p = idx[GW-1:0];
      end
      return p;
   endfunction

   // Round-robin winner among the currently valid requests
   always_comb begin
      w_any = |req_valid;
      w_win = f_pick(req_valid, r_last);
   end

   // Arbitration FSM and registered MMU-side fields
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_last      <= GW'(NUM_REQ - 1);
         r_grant     <= '0;
         r_mmu_valid <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rdata     <= '0;
`ifdef MMU_ARB_TIMEOUT_EN
         r_cnt       <= '0;
         r_timeout   <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant     <= w_win;
                  r_mmu_valid <= 1'b1;
                  r_we        <= req_we[w_win];
                  r_addr      <= req_addr[int'(w_win)*ADDR_W +: ADDR_W];
                  r_wdata     <= req_wdata[int'(w_win)*DATA_W +: DATA_W];
                  r_state     <= S_BUSY;
`ifdef MMU_ARB_TIMEOUT_EN
                  r_cnt       <= '0;
                  r_timeout   <= 1'b0;
`endif
               end
            end
            S_BUSY: begin
               if (mmu_ready) begin
                  r_rdata     <= mmu_data;
                  r_mmu_valid <= 1'b0;
                  r_last      <= r_grant;
                  r_state     <= S_DONE;
               end
`ifdef MMU_ARB_TIMEOUT_EN
               else if (r_cnt == 16'(TIMEOUT - 1)) begin
                  r_rdata     <= '0;
                  r_mmu_valid <= 1'b0;
                  r_last      <= r_grant;
                  r_timeout   <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt       <= r_cnt + 16'd1;
               end
`endif
            end
            S_DONE: begin
               r_state <= S_IDLE;
`ifdef MMU_ARB_TIMEOUT_EN
               r_timeout <= 1'b0;
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // One-hot completion pulse for the granted requester while in DONE
   always_comb begin
      w_ready = '0;
      if (r_state == S_DONE) w_ready[r_grant] = 1'b1;
   end

   assign req_ready   = w_ready;
`ifdef MMU_ARB_TIMEOUT_EN
   assign req_err     = r_timeout ? w_ready : '0;
`else
   assign req_err     = '0;
`endif
   assign req_rdata   = r_rdata;
   assign mmu_valid   = r_mmu_valid;
   assign mmu_we      = r_we;
   assign mmu_address = r_addr;
   assign mmu_wdata   = r_wdata;
   assign grant_id    = r_grant;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mmu_arbiter.sv
// Directed bench for mmu_arbiter (3 requesters, 16-bit fields).
// Timeout scenario runs only when MMU_ARB_TIMEOUT_EN is defined.
module tb_mmu_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid;
   logic [2:0]  req_we;
   logic [47:0] req_addr;
   logic [47:0] req_wdata;
   logic [2:0]  req_ready;
   logic [2:0]  req_err;
   logic [15:0] req_rdata;
   logic        mmu_valid;
   logic        mmu_we;
   logic [15:0] mmu_address;
   logic [15:0] mmu_wdata;
   logic        mmu_ready;
   logic [15:0] mmu_data;
   logic [1:0]  grant_id;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   mmu_arbiter #(
      .NUM_REQ (3),
      .ADDR_W  (16),
      .DATA_W  (16),
      .TIMEOUT (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ready   (req_ready),
      .req_err     (req_err),
      .req_rdata   (req_rdata),
      .mmu_valid   (mmu_valid),
      .mmu_we      (mmu_we),
      .mmu_address (mmu_address),
      .mmu_wdata   (mmu_wdata),
      .mmu_ready   (mmu_ready),
      .mmu_data    (mmu_data),
      .grant_id    (grant_id),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic we,
                          input logic [15:0] a, input logic [15:0] d);
      req_we[i]           = we;
      req_addr[i*16 +: 16]  = a;
      req_wdata[i*16 +: 16] = d;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, {31'd0, mmu_valid}, 32'd0);
      chk({tag, "_we"},    {31'd0, mmu_we}, 32'd0);
      chk({tag, "_addr"},  {16'd0, mmu_address}, 32'd0);
      chk({tag, "_wdata"}, {16'd0, mmu_wdata}, 32'd0);
      chk({tag, "_ready"}, {29'd0, req_ready}, 32'd0);
      chk({tag, "_err"},   {29'd0, req_err}, 32'd0);
      chk({tag, "_rdata"}, {16'd0, req_rdata}, 32'd0);
      chk({tag, "_grant"}, {30'd0, grant_id}, 32'd0);
      chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [1:0] exp_g [6];
      exp_g = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

      rst       = 1'b1;
      req_valid = '0;
      req_we    = '0;
      req_addr  = '0;
      req_wdata = '0;
      mmu_ready = 1'b0;
      mmu_data  = '0;
      #12;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Round-robin: all three hold req_valid, zero-wait MMU
      set_req(0, 1'b0, 16'h0010, 16'h0000);
      set_req(1, 1'b0, 16'h0011, 16'h0000);
      set_req(2, 1'b0, 16'h0012, 16'h0000);
      mmu_ready = 1'b1;
      mmu_data  = 16'hA000;
      req_valid = 3'b111;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("rr%0d_grant", i), {30'd0, grant_id},
             {30'd0, exp_g[i]});
         chk($sformatf("rr%0d_addr", i), {16'd0, mmu_address},
             32'h0010 + 32'(exp_g[i]));
         chk($sformatf("rr%0d_busy", i), {31'd0, mmu_valid & busy}, 32'd1);
         @(negedge clk);
         chk($sformatf("rr%0d_ready", i), {29'd0, req_ready},
             32'd1 << exp_g[i]);
         chk($sformatf("rr%0d_rdata", i), {16'd0, req_rdata}, 32'hA000);
         @(negedge clk);
         chk($sformatf("rr%0d_idle", i), {31'd0, busy}, 32'd0);
      end
      req_valid = '0;
      mmu_ready = 1'b0;

      // Single read, zero wait
      @(negedge clk);
      set_req(0, 1'b0, 16'h0105, 16'h0000);
      mmu_ready = 1'b1;
      mmu_data  = 16'hBEEF;
      req_valid = 3'b001;
      @(negedge clk);
      chk("rd_valid", {31'd0, mmu_valid}, 32'd1);
      chk("rd_addr", {16'd0, mmu_address}, 32'h0105);
      chk("rd_we", {31'd0, mmu_we}, 32'd0);
      chk("rd_noready", {29'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("rd_ready", {29'd0, req_ready}, 32'd1);
      chk("rd_rdata", {16'd0, req_rdata}, 32'hBEEF);
      chk("rd_vdrop", {31'd0, mmu_valid}, 32'd0);
      chk("rd_err", {29'd0, req_err}, 32'd0);
      req_valid = '0;
      mmu_ready = 1'b0;
      @(negedge clk);
      chk("rd_ready_1cyc", {29'd0, req_ready}, 32'd0);

      // Write with four wait states
      set_req(1, 1'b1, 16'h0200, 16'h1234);
      req_valid = 3'b010;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("wr_hold%0d", i),
             {mmu_valid, mmu_we, req_ready, mmu_address, mmu_wdata[10:0]},
             {1'b1, 1'b1, 3'b000, 16'h0200, 11'h234});
         chk($sformatf("wr_wdata%0d", i), {16'd0, mmu_wdata}, 32'h1234);
      end
      chk("wr_grant", {30'd0, grant_id}, 32'd1);
      mmu_ready = 1'b1;
      mmu_data  = 16'h5555;
      @(negedge clk);
      chk("wr_ready", {29'd0, req_ready}, 32'b010);
      chk("wr_capture", {16'd0, req_rdata}, 32'h5555);
      chk("wr_vdrop", {31'd0, mmu_valid}, 32'd0);
      req_valid = '0;
      mmu_ready = 1'b0;
      @(negedge clk);
      chk("wr_idle", {31'd0, busy}, 32'd0);

      // Field isolation: req2 changes its address while BUSY
      set_req(2, 1'b0, 16'h0300, 16'h0000);
      req_valid = 3'b100;
      @(negedge clk);
      chk("iso_grant", {30'd0, grant_id}, 32'd2);
      chk("iso_addr0", {16'd0, mmu_address}, 32'h0300);
      set_req(2, 1'b1, 16'h0777, 16'hFFFF);
      @(negedge clk);
      chk("iso_addr1", {16'd0, mmu_address}, 32'h0300);
      chk("iso_we", {31'd0, mmu_we}, 32'd0);
      chk("iso_wdata", {16'd0, mmu_wdata}, 32'h0000);
      mmu_ready = 1'b1;
      mmu_data  = 16'h0A0A;
      @(negedge clk);
      chk("iso_ready", {29'd0, req_ready}, 32'b100);
      chk("iso_rdata", {16'd0, req_rdata}, 32'h0A0A);
      req_valid = '0;
      mmu_ready = 1'b0;
      @(negedge clk);

      // Reset in the middle of a BUSY transaction
      set_req(1, 1'b1, 16'h0400, 16'h4444);
      req_valid = 3'b010;
      @(negedge clk);
      chk("mid_busy", {31'd0, mmu_valid & busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      mmu_ready = 1'b1;
      @(negedge clk);
      chk("rst_noready", {29'd0, req_ready}, 32'd0);
      rst = 1'b0;
      set_req(0, 1'b0, 16'h0001, 16'h0000);
      set_req(2, 1'b0, 16'h0002, 16'h0000);
      mmu_data  = 16'h7777;
      req_valid = 3'b101;
      @(negedge clk);
      chk("post_grant", {30'd0, grant_id}, 32'd0);
      chk("post_addr", {16'd0, mmu_address}, 32'h0001);
      chk("post_noready", {29'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("post_ready", {29'd0, req_ready}, 32'b001);
      req_valid = 3'b100;
      @(negedge clk);
      @(negedge clk);
      chk("post_grant2", {30'd0, grant_id}, 32'd2);
      @(negedge clk);
      chk("post_ready2", {29'd0, req_ready}, 32'b100);
      chk("post_rdata2", {16'd0, req_rdata}, 32'h7777);
      req_valid = '0;
      mmu_ready = 1'b0;
      @(negedge clk);

`ifdef MMU_ARB_TIMEOUT_EN
      // Watchdog: MMU never answers, TIMEOUT=8
      set_req(0, 1'b0, 16'h0055, 16'h0000);
      req_valid = 3'b001;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("to_wait%0d", i), {29'd0, mmu_valid, req_ready[1:0]},
             32'b100);
      end
      @(negedge clk);
      chk("to_vdrop", {31'd0, mmu_valid}, 32'd0);
      chk("to_ready", {29'd0, req_ready}, 32'b001);
      chk("to_err", {29'd0, req_err}, 32'b001);
      chk("to_rdata", {16'd0, req_rdata}, 32'h0000);
      req_valid = '0;
      @(negedge clk);
      chk("to_err_clr", {29'd0, req_err}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmu_arbiter.md
# mmu_arbiter

Shares the single MMU memory port among `NUM_REQ` requesters: forward-propagation engine, weight/bias loader, and host debug port. Arbitration is round-robin, and each requester keeps one outstanding transaction. The block sits between the compute/loader controllers and the MMU. It serializes one read or write at a time and returns read data and completion to the winning requester.

## Interface
- `NUM_REQ`, 3: number of requesters, 2..8.
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.
- `TIMEOUT`, 255: watchdog limit in cycles, 1..65535; used only with `MMU_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  NUM_REQ  per-requester request; held until its `req_ready` bit pulses.
- `req_we`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data, same packing.
- `req_ready`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `req_err`  out  NUM_REQ  one-cycle timeout pulse, coincident with `req_ready`.
- `req_rdata`  out  DATA_W  read data; valid while any `req_ready` bit is high.
- `mmu_valid`  out  1  transaction strobe to the MMU.
- `mmu_we`  out  1  write enable to the MMU.
- `mmu_address`  out  ADDR_W  MMU address.
- `mmu_wdata`  out  DATA_W  MMU write data.
- `mmu_ready`  in  1  MMU completion; `mmu_data` is valid in the same cycle.
- `mmu_data`  in  DATA_W  MMU read data.
- `grant_id`  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- `busy`  out  1  high in BUSY and DONE.

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If any `req_valid` bit is set, pick a winner round-robin, starting at `last_grant+1` and wrapping modulo NUM_REQ.
  - Register the winner's `we`, `addr` and `wdata` onto the `mmu_*` outputs.
  - Set `mmu_valid`=1, set `grant_id`, then go to BUSY.
- BUSY:
  - Hold the `mmu_*` outputs stable.
  - On `mmu_ready`=1: capture `mmu_data` (captured on writes too), drop `mmu_valid`, update `last_grant` to `grant_id`, go to DONE.
- DONE:
  - Drive `req_ready[grant_id]`=1 for exactly one cycle with `req_rdata` = captured data.
  - Return to IDLE. No arbitration happens in DONE.
- Requester rule: deassert `req_valid` (or present a new request) in the cycle after `req_ready`. A request still asserted in IDLE is treated as a new request.
- `req_valid` is sampled only in IDLE. Changes to `req_*` fields of the granted requester during BUSY are ignored, because the outputs are registered.
- Non-granted requests stay pending with no loss. Starvation bound: at most NUM_REQ-1 other transactions before service.
- On `rst` assertion, including mid-transaction:
  - State goes to IDLE; `mmu_valid`, `mmu_we`, `mmu_address`, `mmu_wdata`, `req_ready`, `req_err`, `req_rdata`, `grant_id` and `busy` all go to 0 immediately.
  - `last_grant` resets to NUM_REQ-1, so requester 0 wins first.
  - No completion pulse is issued for the aborted transaction.

## Timing
- Cycle T: IDLE, `req_valid` sampled.
- T+1: `mmu_valid`=1 with the winner's fields; `busy`=1.
- First cycle with `mmu_ready`=1 (earliest T+1), call it cycle R: data captured.
- R+1: DONE, `req_ready` pulse, `mmu_valid`=0.
- R+2: IDLE; next grant visible at R+3.
- Minimum request-to-completion is 2 cycles; back-to-back issue rate is one transaction per 3 cycles with a zero-wait MMU.
- `mmu_ready` outside BUSY is ignored.

## Configuration
- `MMU_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without `mmu_ready`.
  - When the count reaches TIMEOUT: drop `mmu_valid`, load `req_rdata` = 0, go to DONE, and pulse `req_err[grant_id]` together with `req_ready[grant_id]`.
  - `mmu_ready` in the same cycle as expiry wins: normal completion, no error.
- `MMU_ARB_TIMEOUT_EN` undefined:
  - BUSY waits indefinitely.
  - `req_err` is tied to 0, and the counter and the TIMEOUT parameter are unused.

## Test plan
- **Reset:** assert `rst` mid-BUSY. All outputs are 0 asynchronously and no `req_ready` follows. After release, requester 0 wins first when 0 and 2 request together.
- **Single read:** req0 reads addr 0x0105 and the MMU returns 0xBEEF with zero wait. `mmu_valid` is high at T+1 with address 0x0105, and `req_ready[0]` pulses at T+2 with `req_rdata`=0xBEEF.
- **Round-robin:** all 3 requesters hold `req_valid` continuously (re-requesting after each completion). Grants occur in order 0,1,2,0,1,2, each 3 cycles apart.
- **Write with wait states:** req1 writes 0x1234 to 0x0200 and `mmu_ready` is delayed 4 cycles. `mmu_we`=1 and the fields stay stable for all 4 cycles; `req_ready[1]` pulses 1 cycle after `mmu_ready`.
- **Field isolation:** req2 changes `req_addr` during its BUSY. `mmu_address` keeps the originally granted value.
- **Timeout** (`MMU_ARB_TIMEOUT_EN`, TIMEOUT=8): the MMU never responds. `mmu_valid` drops after 8 BUSY cycles, then `req_ready` and `req_err` pulse together with `req_rdata`=0.
